// File: rtl/tod_pkg.sv
// Shared widths, time limits and alarm state encoding for the time-of-day alarm clock.
package tod_pkg;

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned SEC_W  = 6;

   localparam logic [HOUR_W-1:0] MAX_HOUR  = 5'd23;
   localparam logic [HOUR_W-1:0] NOON_HOUR = 5'd12;
   localparam logic [MIN_W-1:0]  MAX_MIN   = 6'd59;
   localparam logic [SEC_W-1:0]  MAX_SEC   = 6'd59;

   typedef enum logic {
      StIdle,
      StRinging
   } alarm_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC cycles; clear restarts the count.
module tick_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == CntMax)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/tod_alarm_clock.sv
// 24-hour time-of-day clock with loadable time, one alarm with auto-timeout, and 12h display.
module tod_alarm_clock
   import tod_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned ALARM_SECS    = 60
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              propagate,
   input  logic              alarm_set,
   input  logic              alarm_en,
   input  logic              alarm_ack,
   input  logic              mode_12h,
   input  logic [HOUR_W-1:0] in_hours,
   input  logic [MIN_W-1:0]  in_minutes,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic [HOUR_W-1:0] disp_hours,
   output logic              pm,
   output logic              sec_tick,
   output logic              day_wrap,
   output logic              alarm_hit,
   output logic              load_err
);

   localparam logic [7:0] RingLast = 8'(ALARM_SECS - 1);

   logic [HOUR_W-1:0] hours_q, hours_d, alarm_h_q;
   logic [MIN_W-1:0]  minutes_q, minutes_d, alarm_m_q;
   logic [SEC_W-1:0]  seconds_q, seconds_d;
   logic              day_wrap_q, wrap_d, load_err_q;
   logic [7:0]        ring_cnt_q, ring_cnt_d;
   alarm_state_e      state_q, state_d;
   logic              tick_raw, in_valid, do_load, do_alarm_load, match;

   assign in_valid      = (in_hours <= MAX_HOUR) && (in_minutes <= MAX_MIN);
   assign do_load       = propagate && in_valid;
   assign do_alarm_load = alarm_set && in_valid;
   // A load swallows any coincident tick rather than deferring it.
   assign sec_tick      = tick_raw && !do_load;

   tick_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk  (clk),
      .reset(reset),
      .clear(do_load),
      .tick (tick_raw)
   );

   always_comb begin
      hours_d   = hours_q;
      minutes_d = minutes_q;
      seconds_d = seconds_q;
      wrap_d    = 1'b0;
      if (do_load) begin
         hours_d   = in_hours;
         minutes_d = in_minutes;
         seconds_d = '0;
      end else if (sec_tick) begin
         if (seconds_q == MAX_SEC) begin
            seconds_d = '0;
            if (minutes_q == MAX_MIN) begin
               minutes_d = '0;
               if (hours_q == MAX_HOUR) begin
                  hours_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  hours_d = hours_q + HOUR_W'(1);
               end
            end else begin
               minutes_d = minutes_q + MIN_W'(1);
            end
         end else begin
            seconds_d = seconds_q + SEC_W'(1);
         end
      end
   end

   // Only an advance onto hh:mm:00 can fire the alarm, so it cannot retrigger within the minute.
   assign match = alarm_en && (do_load || sec_tick) && (seconds_d == '0) &&
                  (hours_d == alarm_h_q) && (minutes_d == alarm_m_q);

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      case (state_q)
         StIdle: begin
            if (match) begin
               state_d    = StRinging;
               ring_cnt_d = '0;
            end
         end
         StRinging: begin
            if (alarm_ack || !alarm_en) begin
               state_d = StIdle;
            end else if (sec_tick) begin
               if (ring_cnt_q == RingLast) begin
                  state_d = StIdle;
               end else begin
                  ring_cnt_d = ring_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hours_q    <= '0;
         minutes_q  <= '0;
         seconds_q  <= '0;
         alarm_h_q  <= '0;
         alarm_m_q  <= '0;
         day_wrap_q <= 1'b0;
         load_err_q <= 1'b0;
         ring_cnt_q <= '0;
         state_q    <= StIdle;
      end else begin
         hours_q    <= hours_d;
         minutes_q  <= minutes_d;
         seconds_q  <= seconds_d;
         day_wrap_q <= wrap_d;
         load_err_q <= (propagate || alarm_set) && !in_valid;
         ring_cnt_q <= ring_cnt_d;
         state_q    <= state_d;
         if (do_alarm_load) begin
            alarm_h_q <= in_hours;
            alarm_m_q <= in_minutes;
         end
      end
   end

   always_comb begin
      disp_hours = hours_q;
      pm         = 1'b0;
      if (mode_12h) begin
         pm = (hours_q >= NOON_HOUR);
         if (hours_q == '0) begin
            disp_hours = NOON_HOUR;
         end else if (hours_q > NOON_HOUR) begin
            disp_hours = hours_q - NOON_HOUR;
         end
      end
   end

   assign hours     = hours_q;
   assign minutes   = minutes_q;
   assign seconds   = seconds_q;
   assign day_wrap  = day_wrap_q;
   assign load_err  = load_err_q;
   assign alarm_hit = (state_q == StRinging);

endmodule

// File: tb/tb_tod_alarm_clock.sv
// Directed bench for tod_alarm_clock with TICKS_PER_SEC=4, ALARM_SECS=3.
module tb_tod_alarm_clock;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       propagate = 1'b0, alarm_set = 1'b0, alarm_en = 1'b0;
   logic       alarm_ack = 1'b0, mode_12h = 1'b0;
   logic [4:0] in_hours = '0;
   logic [5:0] in_minutes = '0;
   logic [4:0] hours, disp_hours;
   logic [5:0] minutes, seconds;
   logic       pm, sec_tick, day_wrap, alarm_hit, load_err;

   int n_assert = 0;
   int n_fail   = 0;
   int cnt;

   tod_alarm_clock #(
      .TICKS_PER_SEC(4),
      .ALARM_SECS   (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .propagate (propagate),
      .alarm_set (alarm_set),
      .alarm_en  (alarm_en),
      .alarm_ack (alarm_ack),
      .mode_12h  (mode_12h),
      .in_hours  (in_hours),
      .in_minutes(in_minutes),
      .hours     (hours),
      .minutes   (minutes),
      .seconds   (seconds),
      .disp_hours(disp_hours),
      .pm        (pm),
      .sec_tick  (sec_tick),
      .day_wrap  (day_wrap),
      .alarm_hit (alarm_hit),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_time(input int h, input int m);
      propagate  = 1'b1;
      in_hours   = 5'(h);
      in_minutes = 6'(m);
      step(1);
      propagate  = 1'b0;
   endtask

   initial begin
      // Reset state
      step(2);
      chk("rst_hours", 32'(hours), 0);
      chk("rst_minutes", 32'(minutes), 0);
      chk("rst_seconds", 32'(seconds), 0);
      chk("rst_hit", 32'(alarm_hit), 0);
      chk("rst_sec_tick", 32'(sec_tick), 0);
      chk("rst_load_err", 32'(load_err), 0);
      reset = 1'b0;
      step(3);
      chk("first_tick", 32'(sec_tick), 1);
      chk("first_tick_sec", 32'(seconds), 0);
      step(1);
      chk("first_sec", 32'(seconds), 1);

      // Day wrap from 23:59:00 after 240 cycles
      load_time(23, 59);
      chk("load_h", 32'(hours), 23);
      chk("load_m", 32'(minutes), 59);
      chk("load_s", 32'(seconds), 0);
      cnt = 0;
      for (int i = 0; i < 240; i++) begin
         step(1);
         if (day_wrap === 1'b1) cnt++;
      end
      chk("wrap_h", 32'(hours), 0);
      chk("wrap_m", 32'(minutes), 0);
      chk("wrap_s", 32'(seconds), 0);
      chk("wrap_pulse_now", 32'(day_wrap), 1);
      chk("wrap_pulse_count", 32'(cnt), 1);
      step(1);
      chk("wrap_pulse_gone", 32'(day_wrap), 0);

      // Out-of-range loads
      load_time(24, 0);
      chk("err_h_pulse", 32'(load_err), 1);
      chk("err_h_hours", 32'(hours), 0);
      chk("err_h_minutes", 32'(minutes), 0);
      step(1);
      chk("err_pulse_end", 32'(load_err), 0);
      load_time(5, 60);
      chk("err_m_pulse", 32'(load_err), 1);
      chk("err_m_hours", 32'(hours), 0);
      chk("err_m_minutes", 32'(minutes), 0);

      // 12-hour display
      mode_12h = 1'b1;
      load_time(0, 0);
      chk("disp_0", 32'(disp_hours), 12);
      chk("pm_0", 32'(pm), 0);
      load_time(12, 0);
      chk("disp_12", 32'(disp_hours), 12);
      chk("pm_12", 32'(pm), 1);
      load_time(13, 0);
      chk("disp_13", 32'(disp_hours), 1);
      chk("pm_13", 32'(pm), 1);
      mode_12h = 1'b0;
      #1;
      chk("disp_24h_13", 32'(disp_hours), 13);
      chk("pm_24h", 32'(pm), 0);

      // Alarm 04:31 with timeout after 3 seconds
      alarm_set  = 1'b1;
      in_hours   = 5'd4;
      in_minutes = 6'd31;
      step(1);
      alarm_set  = 1'b0;
      alarm_en   = 1'b1;
      load_time(4, 30);
      chk("al_idle", 32'(alarm_hit), 0);
      step(239);
      chk("al_before", 32'(alarm_hit), 0);
      step(1);
      chk("al_rise_m", 32'(minutes), 31);
      chk("al_rise_s", 32'(seconds), 0);
      chk("al_rise", 32'(alarm_hit), 1);
      step(11);
      chk("al_hold_s", 32'(seconds), 2);
      chk("al_hold", 32'(alarm_hit), 1);
      step(1);
      chk("al_timeout_s", 32'(seconds), 3);
      chk("al_timeout", 32'(alarm_hit), 0);

      // Acknowledge one cycle after rising; no retrigger within the minute
      load_time(4, 30);
      step(240);
      chk("ack_rise", 32'(alarm_hit), 1);
      step(1);
      alarm_ack = 1'b1;
      step(1);
      alarm_ack = 1'b0;
      chk("ack_clear", 32'(alarm_hit), 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (alarm_hit !== 1'b0) cnt++;
      end
      chk("ack_no_retrigger", 32'(cnt), 0);

      // Reset while ringing at 04:31:01
      load_time(4, 30);
      step(244);
      chk("mid_ring_s", 32'(seconds), 1);
      chk("mid_ring_hit", 32'(alarm_hit), 1);
      reset = 1'b1;
      #1;
      chk("async_hit", 32'(alarm_hit), 0);
      chk("async_hours", 32'(hours), 0);
      chk("async_minutes", 32'(minutes), 0);
      chk("async_seconds", 32'(seconds), 0);
      step(1);
      reset = 1'b0;

      // Load coincident with a tick discards the tick
      step(3);
      chk("pre_load_tick", 32'(sec_tick), 1);
      propagate  = 1'b1;
      in_hours   = 5'd7;
      in_minutes = 6'd15;
      #1;
      chk("tick_suppressed", 32'(sec_tick), 0);
      step(1);
      propagate = 1'b0;
      chk("coinc_h", 32'(hours), 7);
      chk("coinc_m", 32'(minutes), 15);
      chk("coinc_s", 32'(seconds), 0);
      step(3);
      chk("coinc_s_hold", 32'(seconds), 0);
      step(1);
      chk("coinc_s_next", 32'(seconds), 1);

      // Alarm fired by a load onto the alarm minute, dropped by alarm_en=0
      alarm_set  = 1'b1;
      in_hours   = 5'd7;
      in_minutes = 6'd20;
      step(1);
      alarm_set = 1'b0;
      load_time(7, 20);
      chk("load_match_hit", 32'(alarm_hit), 1);
      alarm_en = 1'b0;
      step(1);
      chk("en_drop", 32'(alarm_hit), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tod_alarm_clock.md
TOD_ALARM_CLOCK -- requirements
Module: tod_alarm_clock

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000, clk cycles per second; legal range 2..2^20.
REQ-002 Parameter ALARM_SECS, default 60, maximum seconds alarm_hit stays asserted without ack; legal range 1..255.
REQ-003 The block SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high, clears all state.
REQ-006 propagate  input  1  load time from in_hours/in_minutes this cycle.
REQ-007 alarm_set  input  1  load alarm time from in_hours/in_minutes this cycle.
REQ-008 alarm_en  input  1  alarm armed when high.
REQ-009 alarm_ack  input  1  clears active alarm.
REQ-010 mode_12h  input  1  selects 12-hour display encoding on disp_hours/pm.
REQ-011 in_hours  input  5  hours 0..23; in_minutes  input  6  minutes 0..59.
REQ-012 hours  output  5  0..23; minutes  output  6  0..59; seconds  output  6  0..59.
REQ-013 disp_hours  output  5  hours if mode_12h=0, else 1..12; pm  output  1  hours>=12 (forced 0 when mode_12h=0).
REQ-014 sec_tick  output  1  one-cycle pulse per second; day_wrap  output  1  one-cycle pulse on 23:59:59->00:00:00.
REQ-015 alarm_hit  output  1  alarm active level; load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-016 Prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; sec_tick SHALL be high in the cycle the count equals TICKS_PER_SEC-1.
REQ-017 On sec_tick seconds SHALL increment; 59->0 carries to minutes; minutes 59->0 carries to hours; hours 23->0 with day_wrap pulsing in the same cycle as the registered wrap.
REQ-018 propagate with valid inputs (hours<=23, minutes<=59) SHALL load hours/minutes, clear seconds and prescaler, visible next cycle; no sec_tick that cycle.
REQ-019 propagate has priority over a coincident sec_tick; the tick is discarded, not deferred.
REQ-020 Out-of-range in_hours or in_minutes on propagate or alarm_set SHALL leave all state unchanged and pulse load_err next cycle.
REQ-021 alarm_set with valid inputs SHALL load alarm registers next cycle; propagate and alarm_set together SHALL both load.
REQ-022 Alarm FSM states IDLE, RINGING: IDLE->RINGING when alarm_en=1 and the time advances to hh:mm:00 equal to the alarm time (tick-driven or loaded via propagate).
REQ-023 RINGING->IDLE on alarm_ack, alarm_en=0, or ALARM_SECS sec_ticks elapsed; alarm_hit=1 exactly while RINGING.
REQ-024 alarm_ack in IDLE SHALL have no effect; a match while RINGING SHALL not restart the ALARM_SECS count.
REQ-025 disp_hours in 12h mode: 0->12, 1..12 unchanged, 13..23->h-12; purely combinational from hours and mode_12h.

Reset
REQ-026 Reset SHALL force hours, minutes, seconds, prescaler, alarm time to 0, FSM to IDLE, all pulses and alarm_hit to 0, asynchronously.
REQ-027 Reset mid-ring SHALL drop alarm_hit immediately; first sec_tick after release occurs TICKS_PER_SEC cycles after the first unreset edge.

Structure
REQ-028 Package tod_pkg SHALL hold width constants (HOUR_W=5, MIN_W=6, SEC_W=6), limits 23/59, and the alarm state enumeration.
REQ-029 Prescaler SHALL be a sub-module tick_prescaler (parameter TICKS_PER_SEC, inputs clk/reset/clear, output tick).

Verification (TICKS_PER_SEC=4, ALARM_SECS=3)
REQ-030 Load 23:59 via propagate, run 4 cycles x 60 -> at 240 cycles 00:00:00, day_wrap single pulse.
REQ-031 propagate in_hours=24 -> load_err pulse, time unchanged; in_minutes=60 likewise.
REQ-032 Alarm 04:31, alarm_en=1, load 04:30 -> alarm_hit rises with 04:31:00, falls after 3 sec_ticks.
REQ-033 Same, alarm_ack 1 cycle after rising -> alarm_hit 0 next cycle; no retrigger within 04:31.
REQ-034 mode_12h=1, hours 0/12/13 -> disp_hours 12/12/1, pm 0/1/1.
REQ-035 Assert reset while RINGING at 04:31:01 -> all outputs 0 immediately; propagate coincident with sec_tick -> loaded value, seconds 0.
